// File: rtl/key_schedule_stream.sv
// key_schedule_stream: AES-128 key expansion, streams round keys 0..NUM_ROUNDS one per handshake
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   key_in[127:0], key_valid  cipher key load (w0 = [127:96]); key_ready high when idle
//   abort                     synchronous flush back to idle
//   round_key[127:0]          current round key, round_key_idx its index
//   rk_valid, rk_ready        round key handshake; rk_last marks index NUM_ROUNDS
module key_schedule_stream #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         abort,
    output logic [127:0] round_key,
    output logic [3:0]   round_key_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last
);
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    // Index 0 and 11..15 are padding so idx+1 can index the table without a range guard.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };
    typedef enum logic {IDLE, RUN} state_t;
    state_t       state, state_nxt;
    logic [127:0] key_reg, key_nxt;
    logic [3:0]   idx;
    logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;
    always_comb begin
        {w0, w1, w2, w3} = key_reg;
        t = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {RCON[idx + 4'd1], 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        key_nxt = {n0, n1, n2, n3};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = abort ? IDLE :
                    state == IDLE ? (key_valid ? RUN : IDLE) :
                    (rk_ready && idx == LAST) ? IDLE : RUN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg <= '0;
            idx     <= '0;
        end else if (abort) begin
            key_reg <= '0;
            idx     <= '0;
        end else if (state == IDLE && key_valid) begin
            key_reg <= key_in;
            idx     <= '0;
        end else if (state == RUN && rk_ready && idx != LAST) begin
            key_reg <= key_nxt;
            idx     <= idx + 4'd1;
        end
    end
    always_comb begin
        key_ready     = state == IDLE;
        rk_valid      = state == RUN;
        rk_last       = state == RUN && idx == LAST;
        round_key     = key_reg;
        round_key_idx = idx;
    end
endmodule

// File: tb/tb_key_schedule_stream.sv
// tb_key_schedule_stream: randomized self-checking bench against a word-level FIPS-197 key expansion model
module tb_key_schedule_stream;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic         abort = 1'b0;
    logic [127:0] round_key;
    logic [3:0]   round_key_idx;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic         rk_last;
    logic [127:0] key_in_s = '0;
    logic         key_valid_s = 1'b0;
    logic         key_ready_s;
    logic [127:0] round_key_s;
    logic [3:0]   round_key_idx_s;
    logic         rk_valid_s;
    logic         rk_ready_s = 1'b0;
    logic         rk_last_s;
    int vectors = 0;
    int miscompares = 0;
    logic [127:0] exp_rk [0:10];
    logic [127:0] got_rk [0:10];

    key_schedule_stream #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .abort(abort), .round_key(round_key), .round_key_idx(round_key_idx),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last)
    );
    key_schedule_stream #(.NUM_ROUNDS(1)) dut_s (
        .clk(clk), .rst(rst), .key_in(key_in_s), .key_valid(key_valid_s), .key_ready(key_ready_s),
        .abort(1'b0), .round_key(round_key_s), .round_key_idx(round_key_idx_s),
        .rk_valid(rk_valid_s), .rk_ready(rk_ready_s), .rk_last(rk_last_s)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int r);
        logic [7:0] c;
        c = 8'h01;
        for (int i = 1; i < r; i++) c = xtime(c);
        return c;
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon(i / 4), 24'h0};
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_key(input logic [127:0] k);
        vectors++;
        if (key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_key key_ready got %b want 1", key_ready);
        end
        key_in = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Consumes round keys up to (not including) index stop_at; stop_at=11 runs the whole schedule.
    task automatic run_schedule(input logic [127:0] k, input int ready_pct, input int stop_at,
                                input logic hold_side, input logic [127:0] side_key);
        int e, budget;
        expand(k);
        e = 0;
        budget = 0;
        while (e < stop_at && budget < 400) begin
            vectors++;
            if (rk_valid !== 1'b1 || round_key !== exp_rk[e] || round_key_idx !== 4'(e) ||
                rk_last !== (e == 10) || key_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL schedule e=%0d got v=%b idx=%0d rk=%h last=%b kr=%b want v=1 idx=%0d rk=%h last=%b kr=0",
                         e, rk_valid, round_key_idx, round_key, rk_last, key_ready, e, exp_rk[e], e == 10);
            end
            got_rk[e] = round_key;
            rk_ready = ($urandom_range(99) < 32'(ready_pct));
            if (hold_side) begin
                key_valid = 1'b1;
                key_in = side_key;
            end
            @(negedge clk);
            if (rk_ready) e++;
            budget++;
        end
        rk_ready = 1'b0;
        if (budget >= 400) begin
            miscompares++;
            $display("FAIL schedule_timeout reached e=%0d want %0d", e, stop_at);
        end
        if (stop_at == 11) begin
            vectors++;
            if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL schedule_end got v=%b kr=%b want v=0 kr=1", rk_valid, key_ready);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1 || round_key !== 128'h0 || round_key_idx !== 4'h0 || rk_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset got v=%b kr=%b rk=%h idx=%0d last=%b want 0 1 0 0 0",
                     rk_valid, key_ready, round_key, round_key_idx, rk_last);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips();
        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, 100, 11, 1'b0, '0);
        vectors++;
        if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            miscompares++;
            $display("FAIL fips_idx1 got %h want a0fafe1788542cb123a339392a6c7605", got_rk[1]);
        end
        vectors++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            miscompares++;
            $display("FAIL fips_idx10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
    endtask

    task automatic test_stall();
        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_schedule(128'h2b7e151628aed2a6abf7158809cf4f3c, 50, 11, 1'b0, '0);
    endtask

    task automatic test_key_ignored();
        logic [127:0] a, b;
        a = rand_key();
        b = rand_key();
        load_key(a);
        run_schedule(a, 70, 11, 1'b1, b);
        @(negedge clk);
        key_valid = 1'b0;
        expand(b);
        vectors++;
        if (rk_valid !== 1'b1 || round_key !== exp_rk[0] || round_key_idx !== 4'h0 || key_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL second_key got v=%b rk=%h idx=%0d kr=%b want v=1 rk=%h idx=0 kr=0",
                     rk_valid, round_key, round_key_idx, key_ready, exp_rk[0]);
        end
        run_schedule(b, 100, 11, 1'b0, '0);
    endtask

    task automatic test_abort();
        logic [127:0] k;
        k = rand_key();
        load_key(k);
        run_schedule(k, 100, 4, 1'b0, '0);
        abort = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        rk_ready = 1'b0;
        vectors++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1 || round_key_idx !== 4'h0) begin
            miscompares++;
            $display("FAIL abort got v=%b kr=%b idx=%0d want v=0 kr=1 idx=0", rk_valid, key_ready, round_key_idx);
        end
        k = rand_key();
        load_key(k);
        run_schedule(k, 60, 11, 1'b0, '0);
    endtask

    task automatic test_async_reset();
        logic [127:0] k;
        k = rand_key();
        load_key(k);
        run_schedule(k, 100, 6, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1 || round_key !== 128'h0 || round_key_idx !== 4'h0 || rk_last !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b kr=%b rk=%h idx=%0d last=%b want 0 1 0 0 0",
                     rk_valid, key_ready, round_key, round_key_idx, rk_last);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_idle got v=%b kr=%b want v=0 kr=1", rk_valid, key_ready);
        end
        k = rand_key();
        load_key(k);
        run_schedule(k, 100, 11, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        for (int n = 0; n < 4; n++) begin
            k = rand_key();
            load_key(k);
            run_schedule(k, 40 + 20 * n, 11, 1'b0, '0);
        end
    endtask

    task automatic test_short_schedule();
        vectors++;
        if (key_ready_s !== 1'b1) begin
            miscompares++;
            $display("FAIL short_ready got %b want 1", key_ready_s);
        end
        key_in_s = '0;
        key_valid_s = 1'b1;
        @(negedge clk);
        key_valid_s = 1'b0;
        vectors++;
        if (rk_valid_s !== 1'b1 || round_key_s !== 128'h0 || round_key_idx_s !== 4'h0 || rk_last_s !== 1'b0) begin
            miscompares++;
            $display("FAIL short_idx0 got v=%b rk=%h idx=%0d last=%b want 1 0 0 0",
                     rk_valid_s, round_key_s, round_key_idx_s, rk_last_s);
        end
        rk_ready_s = 1'b1;
        @(negedge clk);
        vectors++;
        if (rk_valid_s !== 1'b1 || round_key_s !== 128'h62636363626363636263636362636363 ||
            round_key_idx_s !== 4'h1 || rk_last_s !== 1'b1) begin
            miscompares++;
            $display("FAIL short_idx1 got v=%b rk=%h idx=%0d last=%b want v=1 rk=62636363626363636263636362636363 idx=1 last=1",
                     rk_valid_s, round_key_s, round_key_idx_s, rk_last_s);
        end
        @(negedge clk);
        rk_ready_s = 1'b0;
        vectors++;
        if (rk_valid_s !== 1'b0 || key_ready_s !== 1'b1 || rk_last_s !== 1'b0) begin
            miscompares++;
            $display("FAIL short_end got v=%b kr=%b last=%b want 0 1 0", rk_valid_s, key_ready_s, rk_last_s);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips();
        test_stall();
        test_key_ignored();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_short_schedule();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
